// File: rtl/btn_debounce_pulse_pkg.sv
// Shared state encoding for the debouncer and the moore_1-family FSMs it feeds.
package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    function automatic logic is_qualifying(input db_state_t s);
        return (s == RISE_CHK) || (s == FALL_CHK);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad levels; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: synchronise, debounce over STABLE_CYCLES samples,
// and emit one registered pulse per accepted rising edge.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse,
    output logic level,
    output logic busy
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_param
        $error("btn_debounce_pulse: STABLE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s2;
    db_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n, pulse_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= level_n;
            pulse <= pulse_n;
        end
    end

    // cnt saturates at LAST because reaching it always leaves the check state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level;
        pulse_n = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    state_n = RISE_CHK;
                    cnt_n   = ONE;
                end else begin
                    cnt_n   = '0;
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n   = cnt + ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = FALL_CHK;
                    cnt_n   = ONE;
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    level_n = 1'b0;
                end else begin
                    cnt_n   = cnt + ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = is_qualifying(state);

endmodule
